// File: rtl/axis_pkt_tx_pkg.sv
// Shared types and default sizing for the AXI-Stream packet transmitter.
// axis_beat_t is the default-width beat record; the top re-declares it at its own widths.
package axis_pkt_tx_pkg;

   localparam int unsigned AXIS_DATA_W = 64;
   localparam int unsigned AXIS_DEPTH  = 8;
   localparam int unsigned AXIS_LEN_W  = 16;
   localparam int unsigned AXIS_CNT_W  = 16;

   typedef struct packed {
      logic [AXIS_DATA_W-1:0]   data;
      logic [AXIS_DATA_W/8-1:0] keep;
      logic                     eop;
   } axis_beat_t;

endpackage

// File: rtl/axis_pkt_tx_fifo.sv
// Synchronous FIFO of stream beats with an exact 0..DEPTH occupancy count.
// Pointers wrap naturally at DEPTH; full and empty are derived from the level.
module axis_pkt_tx_fifo
   import axis_pkt_tx_pkg::*;
#(
   parameter type         beat_t = axis_beat_t,
   parameter int unsigned DEPTH  = AXIS_DEPTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_i,
   input  beat_t                  wdata_i,
   input  logic                   pop_i,
   output beat_t                  rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   beat_t         mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   level_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (level_q == FULL_LVL);
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + (AW+1)'(1);
            2'b01:   level_q <= level_q - (AW+1)'(1);
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/axis_pkt_tx.sv
// AXI4-Stream master packet transmitter: push port -> FIFO -> registered output slot.
// TLAST comes from the per-beat eop marker or from a packet length latched at each packet's first beat.
module axis_pkt_tx
   import axis_pkt_tx_pkg::*;
#(
   parameter int unsigned DATA_W = AXIS_DATA_W,
   parameter int unsigned DEPTH  = AXIS_DEPTH,
   parameter int unsigned LEN_W  = AXIS_LEN_W,
   parameter int unsigned CNT_W  = AXIS_CNT_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [LEN_W-1:0]       cfg_pkt_len,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_data,
   input  logic [DATA_W/8-1:0]    in_keep,
   input  logic                   in_eop,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic [DATA_W-1:0]      m_tdata,
   output logic [DATA_W/8-1:0]    m_tkeep,
   output logic                   m_tlast,
   output logic [CNT_W-1:0]       pkt_count,
   output logic [$clog2(DEPTH):0] fifo_level
);

   typedef struct packed {
      logic [DATA_W-1:0]   data;
      logic [DATA_W/8-1:0] keep;
      logic                eop;
   } beat_t;

   beat_t               push_beat;
   beat_t               head_beat;
   beat_t               load_beat;
   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_push;
   logic                fifo_pop;
   logic                push_acc;
   logic                pop_out;
   logic                slot_free;
   logic                bypass;
   logic                load;
   logic                last_d;
   logic [LEN_W-1:0]    cfg_eff;
   logic [LEN_W-1:0]    len_use;
   logic [LEN_W-1:0]    cnt_d;
   logic [LEN_W-1:0]    cnt_q;
   logic [LEN_W-1:0]    len_q;
   logic                tvalid_q;
   logic                tlast_q;
   logic [DATA_W-1:0]   tdata_q;
   logic [DATA_W/8-1:0] tkeep_q;
   logic [CNT_W-1:0]    pkt_q;

   assign push_beat = '{data: in_data, keep: in_keep, eop: in_eop};
   assign in_ready  = !fifo_full && !reset;
   assign push_acc  = in_valid && in_ready;
   assign pop_out   = tvalid_q && m_tready;
   assign slot_free = !tvalid_q || pop_out;
   // An empty FIFO lets a pushed beat go straight into a free slot, giving one-cycle latency.
   assign bypass    = push_acc && fifo_empty && slot_free;
   assign fifo_push = push_acc && !bypass;
   assign fifo_pop  = slot_free && !fifo_empty;
   assign load      = fifo_pop || bypass;
   assign load_beat = fifo_empty ? push_beat : head_beat;
   assign cfg_eff   = (cfg_pkt_len == '0) ? LEN_W'(1) : cfg_pkt_len;

   axis_pkt_tx_fifo #(
      .beat_t (beat_t),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (fifo_push),
      .wdata_i (push_beat),
      .pop_i   (fifo_pop),
      .rdata_o (head_beat),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   // cnt_d is the in-packet position of whichever beat occupies the slot after this edge.
   always_comb begin
      cnt_d = cnt_q;
      if (pop_out) begin
         cnt_d = tlast_q ? '0 : cnt_q + LEN_W'(1);
      end
      len_use = (cnt_d == '0) ? cfg_eff : len_q;
      last_d  = load_beat.eop || (cnt_d == len_use - LEN_W'(1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tdata_q  <= '0;
         tkeep_q  <= '0;
         cnt_q    <= '0;
         len_q    <= LEN_W'(1);
         pkt_q    <= '0;
      end else begin
         if (load) begin
            tvalid_q <= 1'b1;
            tdata_q  <= load_beat.data;
            tkeep_q  <= load_beat.keep;
            tlast_q  <= last_d;
            len_q    <= len_use;
         end else if (pop_out) begin
            tvalid_q <= 1'b0;
         end
         cnt_q <= cnt_d;
         if (pop_out && tlast_q) begin
            pkt_q <= pkt_q + CNT_W'(1);
         end
      end
   end

   assign m_tvalid  = tvalid_q;
   assign m_tdata   = tdata_q;
   assign m_tkeep   = tkeep_q;
   assign m_tlast   = tlast_q;
   assign pkt_count = pkt_q;

endmodule

// File: doc/axis_pkt_tx.md
Name: axis_pkt_tx

Overview:
AXI-Stream master-side packet transmitter, the driving end of the stream interface that our AXIS checker monitors.
- Accepts data beats from a simple valid/ready push port.
- Buffers them in a small FIFO.
- Emits them as an AXI4-Stream master with TLAST generated from a programmable packet length, or from a per-beat end-of-packet marker.
- Used as the stream source in block-level and integration benches, and as a reusable RTL transmitter.

Parameters:
DATA_W, 64, TDATA width in bits; multiple of 8.
DEPTH, 8, FIFO entries; power of 2, >= 2.
LEN_W, 16, width of the packet-length config and beat counter.
CNT_W, 16, width of the completed-packet counter.

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
cfg_pkt_len  in  LEN_W  beats per packet; 0 treated as 1
in_valid  in  1  push beat valid
in_ready  out  1  push beat ready
in_data  in  DATA_W  push data
in_keep  in  DATA_W/8  push byte enables
in_eop  in  1  force TLAST on this beat
m_tvalid  out  1  AXIS TVALID
m_tready  in  1  AXIS TREADY
m_tdata  out  DATA_W  AXIS TDATA
m_tkeep  out  DATA_W/8  AXIS TKEEP
m_tlast  out  1  AXIS TLAST
pkt_count  out  CNT_W  completed packets, wrapping
fifo_level  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH

Behaviour:
- Reset, applied on the clock edge while reset=1:
  - m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0.
  - pkt_count=0, fifo_level=0, beat counter=0.
  - in_ready=0 while reset is high; it is combinational !full and rises the first cycle after reset deasserts.
- Reset mid-packet: all buffered beats are discarded and the packet is abandoned. m_tvalid drops the cycle after reset even if a beat was pending. This is the only permitted TVALID withdrawal.
- Push:
  - Beat accepted when in_valid && in_ready.
  - Stored entry = {in_data, in_keep, in_eop}.
  - in_ready = (fifo_level != DEPTH). There is no full-bypass, so push while full is blocked even if a pop happens the same cycle.
- Output stage:
  - A registered output slot is loaded from the FIFO head.
  - Latency from push handshake to m_tvalid is 1 cycle minimum, with the FIFO empty and the output slot empty or being popped.
  - Full throughput is 1 beat/cycle with m_tready held high.
- AXIS rules:
  - Once m_tvalid=1, m_tdata, m_tkeep and m_tlast stay stable until m_tvalid && m_tready.
  - m_tvalid never depends combinationally on m_tready.
- TLAST:
  - The beat counter counts beats handshaken in the current packet.
  - cfg_pkt_len is latched when the first beat of a packet enters the output slot, so changing it mid-packet has no effect.
  - m_tlast=1 if the stored eop=1 OR counter == latched_len-1.
  - On a TLAST handshake: counter is cleared and pkt_count increments, wrapping at 2^CNT_W.
- Simultaneous push and pop:
  - Level is unchanged.
  - With the FIFO empty and the output slot popping, the pushed beat loads the output slot directly.
- Empty: m_tvalid=0 when the output slot is empty. Output register contents are don't-care but held.
- Keep: passed through unmodified, including all-zero keep; null beats are not filtered.
- Level arithmetic is exact 0..DEPTH. Read and write pointers are $clog2(DEPTH) bits and wrap naturally.

Decomposition:
- Package axis_pkt_tx_pkg:
  - typedef axis_beat_t struct {data, keep, eop}, parameterised via DATA_W localparams.
  - Constants for default DATA_W, DEPTH, LEN_W.
- Sub-module axis_pkt_tx_fifo:
  - Synchronous FIFO of axis_beat_t.
  - Ports: push/pop/full/empty/level.
  - The top holds the output slot, beat counter, length latch and pkt_count.

Test Plan:
- Reset then idle: check outputs after reset, with 3 cycles of reset=1 and then release.
  - Required: m_tvalid=0, pkt_count=0, fifo_level=0.
  - Required: in_ready=0 during reset and 1 one cycle after release.
- Length-based TLAST: cfg_pkt_len=4, push 8 beats (data=1..8, eop=0), m_tready=1.
  - Required: TLAST on beats 4 and 8, pkt_count=2.
  - Required: first m_tvalid 1 cycle after the first push, with no bubbles.
- Backpressure and full: DEPTH=8, m_tready=0, push 10 beats.
  - Required: in_ready=0 after 8 accepted entries plus 1 in the output slot, i.e. 9 beats taken; fifo_level=8.
  - Required: m_tdata stable at beat 1 throughout. Releasing m_tready delivers all 10 in order.
- EOP override and length latch: cfg_pkt_len=5, push 3 beats with eop on beat 3, then change cfg_pkt_len=2 mid-next-packet.
  - Required: TLAST on beat 3.
  - Required: the next packet uses whichever length was latched at its first beat.
- Length 0 and wrap: cfg_pkt_len=0 with 70000 single beats, CNT_W=16.
  - Required: every beat has TLAST.
  - Required: pkt_count wraps to 70000-65536=4464.
- Reset mid-packet: cfg_pkt_len=8, reset asserted after 3 of 8 beats handshaken while 4 are buffered.
  - Required: m_tvalid=0 next cycle and fifo_level=0.
  - Required: a new packet afterwards gets TLAST on its 8th beat.
